// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment constants, blink phase type and digit-index width helper
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1100111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        PHASE_VISIBLE = 1'b0,
        PHASE_HIDDEN  = 1'b1
    } blink_phase_t;

    function automatic int digit_idx_width(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - data, mode and display-pin bundle of the scan driver
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    hex_mode;
    logic                    blank_lz;
    logic                    blink_en;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output value_in, dp_in, load, hex_mode, blank_lz, blink_en,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  value_in, dp_in, load, hex_mode, blank_lz, blink_en,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg7_digit_lut.sv
// rtl/seg7_digit_lut.sv - nibble to seven-segment pattern, hex or BCD
module seg7_digit_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (nibble)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: pattern = hex_mode ? SEG_A : SEG_BLANK;
            4'hB: pattern = hex_mode ? SEG_B : SEG_BLANK;
            4'hC: pattern = hex_mode ? SEG_C : SEG_BLANK;
            4'hD: pattern = hex_mode ? SEG_D : SEG_BLANK;
            4'hE: pattern = hex_mode ? SEG_E : SEG_BLANK;
            4'hF: pattern = hex_mode ? SEG_F : SEG_BLANK;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit seven-segment driver with frame-aligned updates and blink
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   bus
);

    localparam int VW    = 4 * NUM_DIGITS;
    localparam int IDX_W = digit_idx_width(NUM_DIGITS);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]      presc_q,   presc_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [VW-1:0]         pend_q,    pend_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_v_q,  pend_v_d;
    logic [VW-1:0]         disp_q,    disp_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
    blink_phase_t          phase_q,   phase_d;
    logic [6:0]            seg_q,     seg_d;
    logic                  dp_q,      dp_d;
    logic [NUM_DIGITS-1:0] an_q,      an_d;

    logic                  scan_tick;
    logic                  frame_end;
    logic                  hidden;
    logic                  lz_blank;
    logic [3:0]            nibs [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] zero_from;
    logic                  zero_run;
    logic [6:0]            lut_pattern;

    assign scan_tick = (presc_q == PRE_LAST);
    assign frame_end = scan_tick && (idx_q == IDX_LAST);
    assign hidden    = bus.blink_en && (phase_q == PHASE_HIDDEN);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
        assign nibs[g] = disp_q[4*g +: 4];
    end

    // zero_from[i]: display digits i and above are all zero
    always_comb begin
        zero_from = '0;
        zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (nibs[i] == 4'h0);
            zero_from[i] = zero_run;
        end
    end

    assign lz_blank = bus.blank_lz && (idx_q != '0) && zero_from[idx_q];

    seg7_digit_lut u_lut (
        .nibble   (nibs[idx_q]),
        .hex_mode (bus.hex_mode),
        .pattern  (lut_pattern)
    );

    always_comb begin
        presc_d   = presc_q + PRE_W'(1);
        idx_d     = idx_q;
        pend_d    = pend_q;
        pend_dp_d = pend_dp_q;
        pend_v_d  = pend_v_q;
        disp_d    = disp_q;
        disp_dp_d = disp_dp_q;
        blk_cnt_d = blk_cnt_q;
        phase_d   = phase_q;

        if (scan_tick) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        // Commit happens before capture so a load on the boundary waits a frame
        if (frame_end && pend_v_q) begin
            disp_d    = pend_q;
            disp_dp_d = pend_dp_q;
            pend_v_d  = 1'b0;
        end
        if (bus.load) begin
            pend_d    = bus.value_in;
            pend_dp_d = bus.dp_in;
            pend_v_d  = 1'b1;
        end

        if (!bus.blink_en) begin
            blk_cnt_d = '0;
            phase_d   = PHASE_VISIBLE;
        end else if (frame_end) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d = '0;
                phase_d   = (phase_q == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
        end
    end

    always_comb begin
        an_d        = '0;
        an_d[idx_q] = 1'b1;
        seg_d       = lz_blank ? SEG_BLANK : lut_pattern;
        dp_d        = disp_dp_q[idx_q];
        if (hidden) begin
            an_d  = '0;
            seg_d = SEG_BLANK;
            dp_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            idx_q     <= '0;
            pend_q    <= '0;
            pend_dp_q <= '0;
            pend_v_q  <= 1'b0;
            disp_q    <= '0;
            disp_dp_q <= '0;
            blk_cnt_q <= '0;
            phase_q   <= PHASE_VISIBLE;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b0;
            an_q      <= '0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            pend_dp_q <= pend_dp_d;
            pend_v_q  <= pend_v_d;
            disp_q    <= disp_d;
            disp_dp_q <= disp_dp_d;
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_end;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver with cycle-level reference model
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int F  = N * SD;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Reference: k counts non-reset edges; digit and frame position derive from k arithmetically
    int          k;
    logic [15:0] shown, pend;
    logic [3:0]  shown_dp, pend_dp;
    bit          pend_v;
    int          fcount;
    int          md;
    bit          mhidden, mbound;
    logic [3:0]  mnib;
    exp_t        me;
    exp_t        exp_q [$];

    always @(posedge clk) begin
        if (rst) begin
            k = 0; shown = '0; pend = '0; shown_dp = '0; pend_dp = '0;
            pend_v = 0; fcount = 0;
            me = '{seg: 7'd0, dp: 1'b0, an: 4'd0, fd: 1'b0};
        end else begin
            md      = (k / SD) % N;
            mhidden = bus.blink_en && (((fcount / BF) % 2) == 1);
            mnib    = 4'((shown >> (4 * md)) & 16'hF);
            if (mhidden) begin
                me.seg = '0; me.dp = 1'b0; me.an = '0;
            end else begin
                me.an  = 4'(1 << md);
                me.dp  = shown_dp[md];
                me.seg = (!bus.hex_mode && mnib > 9) ? 7'd0 : seg_tab[mnib];
                if (bus.blank_lz && md > 0 && (shown >> (4 * md)) == 16'd0) me.seg = '0;
            end
            mbound = (k % F) == F - 1;
            if (!bus.blink_en) fcount = 0;
            else if (mbound) fcount = (fcount + 1) % (2 * BF);
            if (mbound && pend_v) begin
                shown = pend; shown_dp = pend_dp; pend_v = 0;
            end
            if (bus.load) begin
                pend = bus.value_in; pend_dp = bus.dp_in; pend_v = 1;
            end
            k++;
            me.fd = (k % F) == F - 1;
        end
        exp_q.push_back(me);
    end

    exp_t got;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            checks++;
            if (bus.seg !== got.seg || bus.dp !== got.dp || bus.an !== got.an || bus.frame_done !== got.fd) begin
                failures++;
                $display("FAIL scoreboard t=%0t act seg=%b dp=%b an=%b fd=%b exp seg=%b dp=%b an=%b fd=%b",
                         $time, bus.seg, bus.dp, bus.an, bus.frame_done, got.seg, got.dp, got.an, got.fd);
            end
        end
    end

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.value_in = v;
        bus.dp_in    = d;
        bus.load     = 1'b1;
        cycle(1);
        bus.load     = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 4 * F; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s act frame_done never seen exp pulse within %0d cycles", name, 4 * F);
        end
        cycle(1);
    endtask

    task automatic check_digit(input string name, input logic [3:0] target, input logic [6:0] exp_seg);
        bit ok;
        ok = 0;
        for (int i = 0; i < 4 * F; i++) begin
            @(negedge clk);
            if (bus.an === target) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s act an never %b exp within %0d cycles", name, target, 4 * F);
        end else if (bus.seg !== exp_seg) begin
            failures++;
            $display("FAIL %s act seg=%b exp seg=%b", name, bus.seg, exp_seg);
        end
        cycle(1);
    endtask

    int r;
    logic [15:0] rv;

    initial begin
        rst = 1'b1;
        bus.value_in = '0; bus.dp_in = '0; bus.load = 1'b0;
        bus.hex_mode = 1'b0; bus.blank_lz = 1'b0; bus.blink_en = 1'b0;
        cycle(3);
        rst = 1'b0;
        cycle(2 * F + 3);

        do_load(16'h12A9, 4'b0000);
        wait_fd("bcd_commit");
        check_digit("bcd_d1_blank", 4'b0010, 7'b0000000);
        check_digit("bcd_d3_one",   4'b1000, 7'b0000110);
        check_digit("bcd_d0_nine",  4'b0001, 7'b1100111);
        bus.hex_mode = 1'b1;
        check_digit("hex_d1_a",     4'b0010, 7'b1110111);
        do_load(16'h00F0, 4'b0000);
        wait_fd("hex_commit");
        check_digit("hex_d1_f",     4'b0010, 7'b1110001);

        bus.blank_lz = 1'b1;
        do_load(16'h0007, 4'b0000);
        wait_fd("lz_commit");
        check_digit("lz_d2_blank",  4'b0100, 7'b0000000);
        check_digit("lz_d0_seven",  4'b0001, 7'b0000111);
        do_load(16'h0000, 4'b0000);
        wait_fd("lz_zero_commit");
        check_digit("lz_d0_zero",   4'b0001, 7'b0111111);

        do_load(16'h1234, 4'b0100);
        cycle(3 * F);
        bus.blink_en = 1'b1;
        cycle(10 * F + 5);
        bus.blink_en = 1'b0;
        cycle(F + 2);

        cycle(6);
        rst = 1'b1;
        bus.value_in = 16'h5678; bus.load = 1'b1;
        cycle(1);
        bus.load = 1'b0;
        rst = 1'b0;
        cycle(2 * F);
        check_digit("rst_discard",  4'b0001, 7'b0111111);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            rv = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rv = rv & 16'h000F;
                1: rv = rv & 16'h00FF;
                2: rv = rv & 16'h0FFF;
                default: ;
            endcase
            bus.value_in = rv;
            bus.dp_in    = 4'($urandom);
            bus.load     = (r < 80);
            if (r >= 80 && r < 95)   bus.hex_mode = ~bus.hex_mode;
            if (r >= 95 && r < 110)  bus.blank_lz = ~bus.blank_lz;
            if (r >= 110 && r < 120) bus.blink_en = ~bus.blink_en;
            rst = (r >= 995);
            cycle(1);
        end
        rst = 1'b0;
        bus.load = 1'b0;
        cycle(4);
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
